// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters, with a one-entry tagged result register.
// Optional feature: define ADDER_SHARE_SUB_EN to add a per-requester subtract select (req_sub).
module adder_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef ADDER_SHARE_SUB_EN
  input  logic [NREQ-1:0]       req_sub,
`endif
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   w_grant;
  logic [2*NREQ-1:0] w_rot;
  logic             w_accept;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [WIDTH:0]   w_full;

  // Rotate the request vector so bit 0 is the requester at the pointer.
  assign w_rot = {req_valid, req_valid} >> r_ptr;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_grant = IDW'((int'(r_ptr) + k) % NREQ);
    end
  end

  always_comb begin
    w_accept    = !rst && (r_state == S_EMPTY || rsp_ready) && |req_valid;
    w_state_nxt = r_state;
    req_ready   = '0;
    req_ready[w_grant] = w_accept;
    if (w_accept)                              w_state_nxt = S_FULL;
    else if (r_state == S_FULL && rsp_ready)   w_state_nxt = S_EMPTY;
  end

  assign w_a = req_a[int'(w_grant)*WIDTH +: WIDTH];
`ifdef ADDER_SHARE_SUB_EN
  // Subtraction as A + ~B + 1 keeps one adder; carry out becomes not-borrow.
  assign w_cin = req_sub[w_grant];
  assign w_b   = w_cin ? ~req_b[int'(w_grant)*WIDTH +: WIDTH] : req_b[int'(w_grant)*WIDTH +: WIDTH];
`else
  assign w_cin = 1'b0;
  assign w_b   = req_b[int'(w_grant)*WIDTH +: WIDTH];
`endif
  assign w_full = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_ptr     <= '0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        rsp_sum   <= w_full[WIDTH-1:0];
        rsp_carry <= w_full[WIDTH];
        rsp_id    <= w_grant;
        r_ptr     <= IDW'((int'(w_grant) + 1) % NREQ);
      end
    end
  end

  assign rsp_valid = (r_state == S_FULL);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed vectors plus a spec-level model compared every cycle.
module tb_adder_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_sub;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;

  int checks = 0;
  int errors = 0;

  adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef ADDER_SHARE_SUB_EN
    .req_sub   (req_sub),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected output register contents and pointer.
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_sum   = '0;
  logic             m_carry = 1'b0;
  int               m_id    = 0;
  int               m_ptr   = 0;
  bit               started = 1'b0;

  function automatic int m_grant();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    int g = m_grant();
    if (rst || (m_valid && !rsp_ready) || g < 0) return '0;
    return NREQ'(1) << g;
  endfunction

  always @(posedge clk) begin
    int g;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   full;
    started = 1'b1;
    if (rst) begin
      m_valid = 1'b0; m_sum = '0; m_carry = 1'b0; m_id = 0; m_ptr = 0;
    end else begin
      g = m_grant();
      if ((!m_valid || rsp_ready) && g >= 0) begin
        a = req_a[g*WIDTH +: WIDTH];
        b = req_b[g*WIDTH +: WIDTH];
`ifdef ADDER_SHARE_SUB_EN
        if (req_sub[g]) begin
          m_sum   = a - b;
          m_carry = (a >= b);
        end else begin
          full = {1'b0, a} + {1'b0, b};
          m_sum = full[WIDTH-1:0]; m_carry = full[WIDTH];
        end
`else
        full = {1'b0, a} + {1'b0, b};
        m_sum = full[WIDTH-1:0]; m_carry = full[WIDTH];
`endif
        m_id    = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % NREQ;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("req_ready", 64'(req_ready), 64'(m_ready()));
      check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      check("rsp_id",    64'(rsp_id),    64'(m_id));
      check("rsp_sum",   64'(rsp_sum),   64'(m_sum));
      check("rsp_carry", 64'(rsp_carry), 64'(m_carry));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1; req_sub = '0;
    req_a = '0; req_b = '0;
    for (int i = 0; i < NREQ; i++) set_ops(i, WIDTH'(i * 100), WIDTH'(i));

    // Reset held two cycles with every requester valid.
    cycle(); cycle();
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_sum",   64'(rsp_sum),   64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);

    // Round robin with all valid: ids 0,1,2,3,0,1 back to back.
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      cycle();
      check("rr_valid", 64'(rsp_valid), 64'd1);
      check("rr_id",    64'(rsp_id),    64'(n % NREQ));
      check("rr_sum",   64'(rsp_sum),   64'(101 * (n % NREQ)));
    end
    req_valid = '0;
    cycle();
    check("drain_valid", 64'(rsp_valid), 64'd0);

    // Single requester 2.
    req_valid = 4'b0100; set_ops(2, 32'h10, 32'h22);
    cycle();
    req_valid = '0; rsp_ready = 1'b0;
    check("single_valid", 64'(rsp_valid), 64'd1);
    check("single_id",    64'(rsp_id),    64'd2);
    check("single_sum",   64'(rsp_sum),   64'h32);
    check("single_carry", 64'(rsp_carry), 64'd0);

    // Backpressure while requester 1 waits, then drain and refill on one edge.
    req_valid = 4'b0010; set_ops(1, 32'd7, 32'd8);
    for (int n = 0; n < 3; n++) begin
      #1 check("bp_ready", 64'(req_ready), 64'd0);
      cycle();
      check("bp_id",  64'(rsp_id),  64'd2);
      check("bp_sum", 64'(rsp_sum), 64'h32);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", 64'(req_ready), 64'b0010);
    cycle();
    req_valid = '0;
    check("bp_new_id",  64'(rsp_id),  64'd1);
    check("bp_new_sum", 64'(rsp_sum), 64'd15);

    // Modular wrap.
    req_valid = 4'b0001; set_ops(0, 32'hFFFF_FFFF, 32'd1);
    cycle();
    check("wrap_sum",   64'(rsp_sum),   64'd0);
    check("wrap_carry", 64'(rsp_carry), 64'd1);
`ifdef ADDER_SHARE_SUB_EN
    req_sub = 4'b0001; set_ops(0, 32'd5, 32'd7);
    cycle();
    check("sub_sum",   64'(rsp_sum),   64'hFFFF_FFFE);
    check("sub_carry", 64'(rsp_carry), 64'd0);
    req_sub = '0;
`endif

    // Reset while FULL and requester 3 would be granted.
    req_valid = '0; rsp_ready = 1'b0;
    cycle();
    rsp_ready = 1'b1; req_valid = 4'b1000; set_ops(3, 32'd1, 32'd2); rst = 1'b1;
    #1 check("midrst_ready", 64'(req_ready), 64'd0);
    cycle();
    check("midrst_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    cycle();
    check("midrst_regrant_id",  64'(rsp_id),  64'd3);
    check("midrst_regrant_sum", 64'(rsp_sum), 64'd3);

    // Mixed traffic checked by the model alone.
    for (int n = 0; n < 60; n++) begin
      req_valid = NREQ'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_sub   = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, (n % 5 == 0) ? 32'd1 : $urandom);
      cycle();
    end

    req_valid = '0;
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
